// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the accumulator RISC CPU.
// Registered outputs decode the next state so they align with state.
module multicycle_controller #(
  parameter int OPC_W    = 3,
  parameter int ALU_OP_W = 2,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                acc_zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                addr_sel,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_load,
  output logic                acc_write,
  output logic                alu_to_acc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                pc_inc,
  output logic                skip,
  output logic                jump,
  output logic                halt,
  output logic                bus_err,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IADDR  = 3'd0,
    S_IFETCH = 3'd1,
    S_DECODE = 3'd2,
    S_OADDR  = 3'd3,
    S_OFETCH = 3'd4,
    S_EXEC   = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  function automatic logic is_nop(input logic [OPC_W-1:0] o);
    return (o >> 3) != '0;
  endfunction

  state_e              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic                acc_z_q, acc_z_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                bus_err_q, bus_err_d;
  logic                stall;
  logic                q_sto;

  logic                addr_sel_q, addr_sel_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                ir_load_q, ir_load_d;
  logic                acc_write_q, acc_write_d;
  logic                alu_to_acc_q, alu_to_acc_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic                pc_inc_q, pc_inc_d;
  logic                skip_q, skip_d;
  logic                jump_q, jump_d;
  logic                halt_q, halt_d;

  assign q_sto = !is_nop(opc_q) && (opc_q[2:0] == OP_STO);

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    acc_z_d   = acc_z_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    stall     = 1'b0;
    unique case (state_q)
      S_IADDR: begin
        state_d = S_IFETCH;
        wait_d  = '0;
      end
      S_IFETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           stall   = 1'b1;
      end
      S_DECODE: begin
        opc_d   = opcode;
        acc_z_d = acc_zero;
        if (is_nop(opcode)) begin
          state_d = S_PCUPD;
        end else begin
          unique case (opcode[2:0])
            OP_HLT:         state_d = S_HALT;
            OP_SKZ, OP_JMP: state_d = S_PCUPD;
            default:        state_d = S_OADDR;
          endcase
        end
      end
      S_OADDR: begin
        state_d = q_sto ? S_EXEC : S_OFETCH;
        wait_d  = '0;
      end
      S_OFETCH: begin
        if (mem_ready) state_d = S_EXEC;
        else           stall   = 1'b1;
      end
      S_EXEC: begin
        if (!q_sto || mem_ready) state_d = S_PCUPD;
        else                     stall   = 1'b1;
      end
      S_PCUPD: state_d = S_IADDR;
      S_HALT: if (resume) state_d = S_PCUPD;
    endcase
    // Timeout halts like HLT so a resume advances past the instruction.
    if (stall) begin
      wait_d = wait_q + 1'b1;
      if (wait_d == WAIT_MAX) begin
        state_d   = S_HALT;
        bus_err_d = 1'b1;
        opc_d     = '0;
      end
    end
  end

  always_comb begin
    addr_sel_d   = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    ir_load_d    = 1'b0;
    acc_write_d  = 1'b0;
    alu_to_acc_d = 1'b0;
    alu_op_d     = '0;
    pc_inc_d     = 1'b0;
    skip_d       = 1'b0;
    jump_d       = 1'b0;
    halt_d       = 1'b0;
    unique case (state_d)
      S_IADDR:  ;
      S_IFETCH: mem_read_d = 1'b1;
      S_DECODE: ir_load_d = 1'b1;
      S_OADDR:  addr_sel_d = 1'b1;
      S_OFETCH: begin
        addr_sel_d = 1'b1;
        mem_read_d = 1'b1;
      end
      S_EXEC: begin
        addr_sel_d = 1'b1;
        if (!is_nop(opc_d)) begin
          unique case (opc_d[2:0])
            OP_ADD: begin
              acc_write_d  = 1'b1;
              alu_to_acc_d = 1'b1;
              alu_op_d     = ALU_OP_W'(1);
            end
            OP_AND: begin
              acc_write_d  = 1'b1;
              alu_to_acc_d = 1'b1;
              alu_op_d     = ALU_OP_W'(2);
            end
            OP_XOR: begin
              acc_write_d  = 1'b1;
              alu_to_acc_d = 1'b1;
              alu_op_d     = ALU_OP_W'(3);
            end
            OP_LDA:  acc_write_d = 1'b1;
            OP_STO:  mem_write_d = 1'b1;
            default: ;
          endcase
        end
      end
      S_PCUPD: begin
        if (!is_nop(opc_d) && opc_d[2:0] == OP_JMP) begin
          jump_d = 1'b1;
        end else begin
          pc_inc_d = 1'b1;
          skip_d   = !is_nop(opc_d) && (opc_d[2:0] == OP_SKZ) && acc_z_d;
        end
      end
      S_HALT: halt_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IADDR;
      opc_q        <= '0;
      acc_z_q      <= 1'b0;
      wait_q       <= '0;
      bus_err_q    <= 1'b0;
      addr_sel_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ir_load_q    <= 1'b0;
      acc_write_q  <= 1'b0;
      alu_to_acc_q <= 1'b0;
      alu_op_q     <= '0;
      pc_inc_q     <= 1'b0;
      skip_q       <= 1'b0;
      jump_q       <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      acc_z_q      <= acc_z_d;
      wait_q       <= wait_d;
      bus_err_q    <= bus_err_d;
      addr_sel_q   <= addr_sel_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ir_load_q    <= ir_load_d;
      acc_write_q  <= acc_write_d;
      alu_to_acc_q <= alu_to_acc_d;
      alu_op_q     <= alu_op_d;
      pc_inc_q     <= pc_inc_d;
      skip_q       <= skip_d;
      jump_q       <= jump_d;
      halt_q       <= halt_d;
    end
  end

  assign addr_sel   = addr_sel_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign ir_load    = ir_load_q;
  assign acc_write  = acc_write_q;
  assign alu_to_acc = alu_to_acc_q;
  assign alu_op     = alu_op_q;
  assign pc_inc     = pc_inc_q;
  assign skip       = skip_q;
  assign jump       = jump_q;
  assign halt       = halt_q;
  assign bus_err    = bus_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a 4-bit opcode.
// Outputs are sampled 1 time unit after each rising edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       acc_zero;
  logic       mem_ready;
  logic       resume;
  logic       addr_sel, mem_read, mem_write, ir_load;
  logic       acc_write, alu_to_acc, pc_inc, skip;
  logic       jump, halt, bus_err;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [12:0] outs;

  int checks = 0;
  int failures = 0;

  multicycle_controller #(
    .OPC_W(4), .ALU_OP_W(2), .MAX_WAIT(15), .WAIT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .acc_zero(acc_zero), .mem_ready(mem_ready),
    .resume(resume), .addr_sel(addr_sel),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_load(ir_load), .acc_write(acc_write),
    .alu_to_acc(alu_to_acc), .alu_op(alu_op),
    .pc_inc(pc_inc), .skip(skip), .jump(jump),
    .halt(halt), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {addr_sel, mem_read, mem_write, ir_load,
                 acc_write, alu_to_acc, alu_op, pc_inc,
                 skip, jump, halt, bus_err};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", state);
    end
    checks++;
    if (outs !== 13'd0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0", outs);
    end
    repeat (2) tick();
    checks++;
    if (state !== 3'd0 || outs !== 13'd0) begin
      failures++;
      $display("FAIL reset_hold got=%0d/%h exp=0/0", state, outs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [2:0] exp_st [8];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    opcode = 4'd2;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (state !== exp_st[i]) begin
        failures++;
        $display("FAIL add_state%0d got=%0d exp=%0d", i, state, exp_st[i]);
      end
      if (i == 5) begin
        checks++;
        if ({acc_write, alu_to_acc, alu_op, mem_write} !== 5'b11010) begin
          failures++;
          $display("FAIL add_exec got=%b exp=11010",
                   {acc_write, alu_to_acc, alu_op, mem_write});
        end
      end
      if (i == 6) begin
        checks++;
        if ({pc_inc, skip, jump} !== 3'b100) begin
          failures++;
          $display("FAIL add_pcupd got=%b exp=100", {pc_inc, skip, jump});
        end
      end
      if (i < 7) tick();
    end
  endtask

  task automatic test_alu_ops;
    logic [3:0] ops [3];
    logic [2:0] exp [3];
    ops = '{4'd3, 4'd4, 4'd5};
    exp = '{3'b110, 3'b111, 3'b000};
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      repeat (5) tick();
      checks++;
      if (state !== 3'd5 || acc_write !== 1'b1 ||
          {alu_to_acc, alu_op} !== exp[k]) begin
        failures++;
        $display("FAIL alu_op%0d got=%0d/%b/%b exp=5/1/%b", ops[k],
                 state, acc_write, {alu_to_acc, alu_op}, exp[k]);
      end
      repeat (2) tick();
    end
  endtask

  task automatic test_sto;
    opcode = 4'd6;
    mem_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL sto_oaddr got=%0d exp=3", state);
    end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 3'd5 || mem_write !== 1'b1 ||
          acc_write !== 1'b0 || mem_read !== 1'b0) begin
        failures++;
        $display("FAIL sto_wait%0d got=%0d/%b/%b/%b exp=5/1/0/0", i,
                 state, mem_write, acc_write, mem_read);
      end
      mem_ready = (i == 3);
      tick();
    end
    checks++;
    if (state !== 3'd6 || mem_write !== 1'b0 || pc_inc !== 1'b1) begin
      failures++;
      $display("FAIL sto_pcupd got=%0d/%b/%b exp=6/0/1",
               state, mem_write, pc_inc);
    end
    tick();
  endtask

  task automatic test_skz;
    logic [1:0] exp [2];
    exp = '{2'b11, 2'b01};
    mem_ready = 1'b1;
    opcode = 4'd1;
    for (int k = 0; k < 2; k++) begin
      acc_zero = (k == 0);
      repeat (3) tick();
      checks++;
      if (state !== 3'd6 || {skip, pc_inc} !== exp[k] || jump !== 1'b0) begin
        failures++;
        $display("FAIL skz%0d got=%0d/%b/%b exp=6/%b/0", k,
                 state, {skip, pc_inc}, jump, exp[k]);
      end
      tick();
    end
    acc_zero = 1'b0;
  endtask

  task automatic test_jmp;
    opcode = 4'd7;
    repeat (3) tick();
    checks++;
    if (state !== 3'd6 || jump !== 1'b1 || pc_inc !== 1'b0) begin
      failures++;
      $display("FAIL jmp got=%0d/%b/%b exp=6/1/0", state, jump, pc_inc);
    end
    tick();
    checks++;
    if (state !== 3'd0 || jump !== 1'b0) begin
      failures++;
      $display("FAIL jmp_next got=%0d/%b exp=0/0", state, jump);
    end
  endtask

  task automatic test_halt;
    opcode = 4'd0;
    resume = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (state !== 3'd7 || halt !== 1'b1) begin
        failures++;
        $display("FAIL halt_hold%0d got=%0d/%b exp=7/1", i, state, halt);
      end
      tick();
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++;
    if (state !== 3'd6 || pc_inc !== 1'b1 || halt !== 1'b0) begin
      failures++;
      $display("FAIL halt_resume got=%0d/%b/%b exp=6/1/0",
               state, pc_inc, halt);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL halt_iaddr got=%0d exp=0", state);
    end
  endtask

  task automatic test_timeout;
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_pre got=%b exp=0", bus_err);
    end
    opcode = 4'd2;
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (state !== 3'd1 || mem_read !== 1'b1) begin
        failures++;
        $display("FAIL tmo_wait%0d got=%0d/%b exp=1/1", i, state, mem_read);
      end
      tick();
    end
    checks++;
    if (state !== 3'd7 || bus_err !== 1'b1 ||
        mem_read !== 1'b0 || halt !== 1'b1) begin
      failures++;
      $display("FAIL tmo_halt got=%0d/%b/%b/%b exp=7/1/0/1",
               state, bus_err, mem_read, halt);
    end
    mem_ready = 1'b1;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++;
    if (state !== 3'd6 || pc_inc !== 1'b1 || bus_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_resume got=%0d/%b/%b exp=6/1/1",
               state, pc_inc, bus_err);
    end
    tick();
    checks++;
    if (state !== 3'd0 || bus_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sticky got=%0d/%b exp=0/1", state, bus_err);
    end
  endtask

  task automatic test_nop;
    logic [2:0] exp_st [4];
    exp_st = '{3'd1, 3'd2, 3'd6, 3'd0};
    opcode = 4'b1010;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== exp_st[i] || acc_write !== 1'b0 || mem_write !== 1'b0) begin
        failures++;
        $display("FAIL nop%0d got=%0d/%b/%b exp=%0d/0/0", i,
                 state, acc_write, mem_write, exp_st[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    opcode = 4'd2;
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if (state !== 3'd4 || mem_read !== 1'b1 || addr_sel !== 1'b1) begin
      failures++;
      $display("FAIL mid_ofetch got=%0d/%b/%b exp=4/1/1",
               state, mem_read, addr_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || outs !== 13'd0) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%h exp=0/0", state, outs);
    end
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1 || mem_write !== 1'b0) begin
      failures++;
      $display("FAIL mid_restart got=%0d/%b exp=1/0", state, mem_write);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = '0;
    acc_zero = 1'b0;
    mem_ready = 1'b1;
    resume = 1'b0;
    test_reset();
    test_add();
    test_alu_ops();
    test_sto();
    test_skz();
    test_jmp();
    test_halt();
    test_timeout();
    test_nop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle sequencer for the accumulator RISC CPU; it supersedes the single-edge opcode decoder.
- Steps each instruction through fetch, decode, operand, execute and PC-update phases.
- Stalls on a memory-ready handshake, with a wait-state timeout.
- Provides a resumable halt and a conditional skip using the accumulator zero flag.
- Sits between the instruction bus / IR and the PC, memory, ALU and ACC enables.

Parameters:
- OPC_W, 3, opcode width. Must be >= 3. Low 3 bits carry the base ISA; any nonzero upper bit decodes as NOP.
- ALU_OP_W, 2, width of alu_op.
- MAX_WAIT, 15, maximum cycles the block waits for mem_ready in a memory phase before declaring bus error.
- WAIT_W, 4, wait counter width. Must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPC_W  opcode field of the instruction bus; sampled in DECODE
- acc_zero  in  1  accumulator == 0; sampled in DECODE
- mem_ready  in  1  memory completes the current read/write this cycle
- resume  in  1  leave HALT state
- addr_sel  out  1  0 = address from PC, 1 = address from IR operand
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- ir_load  out  1  instruction register load enable
- acc_write  out  1  accumulator write enable
- alu_to_acc  out  1  1 = ACC input from ALU, 0 = from memory data
- alu_op  out  ALU_OP_W  00 pass, 01 add, 10 and, 11 xor
- pc_inc  out  1  increment PC
- skip  out  1  with pc_inc, PC advances by 2
- jump  out  1  load PC from IR operand
- halt  out  1  CPU halted
- bus_err  out  1  sticky memory-timeout flag
- state  out  3  current phase, for debug

Behaviour:
- Async reset (rst_n=0): state=IADDR, wait counter=0, opc_q=0, acc_z_q=0, bus_err=0, every output 0.
- Outputs are registered and change only on rising clk. Their value in each cycle is a function of the current state, opc_q and acc_z_q only.
- State encoding:
  - IADDR=0
  - IFETCH=1
  - DECODE=2
  - OADDR=3
  - OFETCH=4
  - EXEC=5
  - PCUPD=6
  - HALT=7
- Base opcodes (low 3 bits, upper bits zero): HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- IADDR: addr_sel=0. Next state is IFETCH.
- IFETCH: addr_sel=0, mem_read=1. Stays until mem_ready=1, then goes to DECODE.
- DECODE:
  - ir_load=1.
  - On exit, opc_q<=opcode and acc_z_q<=acc_zero.
  - HLT goes to HALT.
  - SKZ, JMP and NOP go to PCUPD.
  - All other opcodes go to OADDR.
- OADDR: addr_sel=1.
  - STO goes to EXEC.
  - ADD, AND, XOR and LDA go to OFETCH.
- OFETCH: addr_sel=1, mem_read=1. Stays until mem_ready=1, then goes to EXEC.
- EXEC: addr_sel=1.
  - ADD, AND, XOR: acc_write=1, alu_to_acc=1, alu_op=01/10/11 respectively. Goes to PCUPD.
  - LDA: acc_write=1, alu_to_acc=0, alu_op=00. Goes to PCUPD.
  - STO: mem_write=1. Stays until mem_ready=1, then goes to PCUPD.
- PCUPD: next state is IADDR.
  - JMP: jump=1, pc_inc=0.
  - SKZ: pc_inc=1, skip=acc_z_q.
  - Everything else: pc_inc=1.
- HALT: halt=1. When resume=1, goes to PCUPD with pc_inc=1, so execution continues at the next instruction.
- Latency with mem_ready held at 1:
  - ADD/AND/XOR/LDA: 7 cycles.
  - STO: 6 cycles.
  - SKZ/JMP/NOP: 4 cycles.
  - HLT: 3 cycles to first halt=1.
- Wait counter:
  - Cleared on entry to IFETCH, OFETCH and STO-EXEC.
  - Increments on each cycle in those states with mem_ready=0.
  - If it reaches MAX_WAIT with mem_ready still 0: go to HALT, set bus_err=1, drop the memory enable.
  - bus_err stays set until reset; resume from this HALT is still honoured.
- mem_ready outside a wait state is ignored. mem_read and mem_write are never both 1.
- Reset asserted mid-instruction aborts immediately. No memory write is issued after rst_n falls.

Test Plan:
- Reset, then ADD (opcode=2), mem_ready=1 -> states 0,1,2,3,4,5,6,0. EXEC has acc_write=1, alu_to_acc=1, alu_op=01. PCUPD has pc_inc=1.
- STO (6), mem_ready low for 3 cycles in EXEC -> mem_write=1 held 4 cycles, acc_write stays 0, then PCUPD.
- SKZ with acc_zero=1 at DECODE, then SKZ with acc_zero=0 -> PCUPD gives skip=1/pc_inc=1, then skip=0/pc_inc=1. JMP (7) -> jump=1, pc_inc=0.
- HLT (0) -> halt=1 held 10 cycles while resume=0. Pulse resume -> PCUPD with pc_inc=1, then IADDR.
- mem_ready held 0 in IFETCH -> after MAX_WAIT=15 cycles: HALT, bus_err=1, mem_read=0.
- OPC_W=4 with opcode=4'b1010 -> NOP path, 4 cycles, no acc_write or mem_write. rst_n low in OFETCH -> all outputs 0 asynchronously, state=0.
